// File: rtl/rr_arb16_ctrl_pkg.sv
// Shared constants and state encoding for the 16-way round-robin arbiter.
// The top module and the bench both import this package.
package rr_arb16_ctrl_pkg;

    localparam int NUM_REQ = 16;
    localparam int IDX_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb16_ctrl_dec.sv
// 4-to-16 one-hot decoder; a is the MSB and d is the LSB of the select index.
module dec4to16 (
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        d,
    output logic [15:0] y
);

    logic [3:0] sel;

    assign sel = {a, b, c, d};

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_dec
            assign y[gi] = (sel == 4'(gi));
        end
    endgenerate

endmodule

// File: rtl/rr_arb16_ctrl.sv
// Round-robin arbiter for 16 requesters with a bounded hold time and a
// one-cycle idle gap between owners; the one-hot grant comes from a 4-to-16 decoder.
module rr_arb16_ctrl
    import rr_arb16_ctrl_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid,
    output logic               preempt
);

    localparam int HC_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   grant_idx_reg, grant_idx_next;
    logic               grant_valid_reg, grant_valid_next;
    logic               preempt_reg, preempt_next;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;
    logic [HC_W-1:0]    hold_cnt_reg, hold_cnt_next;

    logic [IDX_W:0]     pick;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               owner_req;
    logic               hold_expired;
    logic [NUM_REQ-1:0] dec_y;

    // Returns {found, index}: first set bit of r scanning upward from p with 4-bit wrap.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   p);
        logic             found;
        logic [IDX_W-1:0] win;
        logic [IDX_W-1:0] idx;
        found = 1'b0;
        win   = p;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = p + IDX_W'(k);
            if (!found && r[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            grant_idx_reg   <= '0;
            grant_valid_reg <= 1'b0;
            preempt_reg     <= 1'b0;
            ptr_reg         <= '0;
            hold_cnt_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            grant_idx_reg   <= grant_idx_next;
            grant_valid_reg <= grant_valid_next;
            preempt_reg     <= preempt_next;
            ptr_reg         <= ptr_next;
            hold_cnt_reg    <= hold_cnt_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        grant_idx_next   = grant_idx_reg;
        grant_valid_next = grant_valid_reg;
        preempt_next     = 1'b0;
        ptr_next         = ptr_reg;
        hold_cnt_next    = hold_cnt_reg;

        pick         = rr_pick(req, ptr_reg);
        pick_found   = pick[IDX_W];
        pick_idx     = pick[IDX_W-1:0];
        owner_req    = req[grant_idx_reg];
        hold_expired = (HOLD_MAX != 0) && (hold_cnt_reg == HOLD_LAST);

        case (state_reg)
            ST_IDLE, ST_GAP: begin
                if (pick_found) begin
                    state_next       = ST_GRANT;
                    grant_idx_next   = pick_idx;
                    grant_valid_next = 1'b1;
                    hold_cnt_next    = '0;
                end else begin
                    state_next       = ST_IDLE;
                    grant_valid_next = 1'b0;
                end
            end
            ST_GRANT: begin
                if (!owner_req || hold_expired) begin
                    // Moving ptr past the owner makes a pre-empted requester lowest priority.
                    state_next       = ST_GAP;
                    grant_valid_next = 1'b0;
                    ptr_next         = IDX_W'(grant_idx_reg + 1);
                    preempt_next     = owner_req;
                end else begin
                    hold_cnt_next = HC_W'(hold_cnt_reg + 1);
                end
            end
            default: begin
                state_next       = ST_IDLE;
                grant_valid_next = 1'b0;
            end
        endcase
    end

    dec4to16 u_dec (
        .a (grant_idx_reg[3]),
        .b (grant_idx_reg[2]),
        .c (grant_idx_reg[1]),
        .d (grant_idx_reg[0]),
        .y (dec_y)
    );

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
            assign grant[gi] = dec_y[gi] & grant_valid_reg;
        end
    endgenerate

    assign grant_idx   = grant_idx_reg;
    assign grant_valid = grant_valid_reg;
    assign preempt     = preempt_reg;

endmodule

// File: tb/tb_rr_arb16_ctrl.sv
// Bench for rr_arb16_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against an owner/queue-level model.
module tb_rr_arb16_ctrl;
    import rr_arb16_ctrl_pkg::*;

    localparam int TB_HOLD = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = '0;
    logic [15:0] grant;
    logic [3:0]  grant_idx;
    logic        grant_valid;
    logic        preempt;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: who owns the resource and for how many cycles so far.
    int  m_owner = -1;
    int  m_held  = 0;
    int  m_ptr   = 0;
    int  m_idx   = 0;
    bit  m_gap   = 0;
    bit  m_pre   = 0;
    bit  m_live  = 0;

    rr_arb16_ctrl #(.HOLD_MAX(TB_HOLD)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .preempt     (preempt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Applies one rising edge worth of rules to the model, using the inputs just sampled.
    task automatic model_update();
        int w;
        if (rst) begin
            m_owner = -1; m_held = 0; m_ptr = 0; m_idx = 0; m_gap = 0; m_pre = 0;
            m_live  = 1;
        end else if (m_owner >= 0) begin
            if (!req[m_owner] || (TB_HOLD != 0 && m_held == TB_HOLD)) begin
                m_pre   = req[m_owner];
                m_ptr   = (m_owner + 1) % 16;
                m_owner = -1;
                m_gap   = 1;
            end else begin
                m_held++;
            end
        end else begin
            m_gap = 0;
            m_pre = 0;
            w = -1;
            for (int k = 0; k < 16; k++)
                if (w < 0 && req[(m_ptr + k) % 16]) w = (m_ptr + k) % 16;
            if (w >= 0) begin
                m_owner = w;
                m_idx   = w;
                m_held  = 1;
                $display("grant start idx=%0d req=%04h", w, req);
            end
        end
    endtask

    // The single per-cycle compare process.
    always @(negedge clk) begin
        if (m_live) begin
            chk("grant_valid", grant_valid, (m_owner >= 0));
            chk("grant_idx",   grant_idx,   m_idx);
            chk("grant",       grant,       (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            chk("preempt",     preempt,     m_pre);
        end
    end

    task automatic step(input logic rst_v, input logic [15:0] req_v);
        rst = rst_v;
        req = req_v;
        @(posedge clk);
        model_update();
        @(negedge clk);
        #1;
    endtask

    initial begin
        @(negedge clk);

        // Reset with every requester active.
        step(1'b1, 16'hFFFF);
        step(1'b1, 16'hFFFF);
        chk("rst_grant", grant, 16'h0000);
        chk("rst_valid", grant_valid, 1'b0);
        chk("rst_idx", grant_idx, 4'd0);
        chk("rst_preempt", preempt, 1'b0);
        step(1'b0, 16'hFFFF);
        chk("post_rst_grant", grant, 16'h0001);
        $display("reset scenario done");

        // Single requester 5 for three cycles, then the pointer must sit at 6.
        step(1'b1, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0020);
            chk("single_grant", grant, 16'h0020);
            chk("single_idx", grant_idx, 4'd5);
        end
        step(1'b0, 16'h0000);
        chk("single_gap", grant_valid, 1'b0);
        step(1'b0, 16'h0000);
        chk("single_idle", grant_valid, 1'b0);
        step(1'b0, 16'h0041);
        chk("ptr_after_single", grant_idx, 4'd6);
        $display("single requester scenario done");

        // Rotation between 0 and 15 across the wrap.
        step(1'b1, 16'h0000);
        for (int r = 0; r < 4; r++) begin
            logic [3:0] own;
            own = (r % 2 == 1) ? 4'd15 : 4'd0;
            step(1'b0, 16'h8001);
            chk("rot_idx", grant_idx, own);
            step(1'b0, 16'h8001);
            chk("rot_hold", grant_valid, 1'b1);
            step(1'b0, (own == 4'd0) ? 16'h8000 : 16'h0001);
            chk("rot_gap", grant_valid, 1'b0);
        end
        $display("rotation scenario done");

        // Pre-emption with two steady requesters.
        step(1'b1, 16'h0000);
        for (int r = 0; r < 3; r++) begin
            logic [3:0] own;
            own = (r % 2 == 1) ? 4'd3 : 4'd0;
            for (int c = 0; c < TB_HOLD; c++) begin
                step(1'b0, 16'h0009);
                chk("pre_idx", grant_idx, own);
                chk("pre_valid", grant_valid, 1'b1);
            end
            step(1'b0, 16'h0009);
            chk("pre_pulse", preempt, 1'b1);
            chk("pre_gap", grant_valid, 1'b0);
        end
        $display("preemption scenario done");

        // Reset while idx 7 is mid-hold.
        step(1'b1, 16'h0000);
        for (int c = 0; c < 4; c++) step(1'b0, 16'h0080);
        chk("midrst_pre", grant_idx, 4'd7);
        step(1'b1, 16'h0081);
        chk("midrst_grant", grant, 16'h0000);
        step(1'b0, 16'h0081);
        chk("midrst_after", grant_idx, 4'd0);
        $display("mid-grant reset scenario done");

        // Owner 2 drops as 9 rises.
        step(1'b1, 16'h0000);
        step(1'b0, 16'h0004);
        step(1'b0, 16'h0004);
        step(1'b0, 16'h0200);
        chk("simul_gap", grant_valid, 1'b0);
        chk("simul_nopre", preempt, 1'b0);
        step(1'b0, 16'h0200);
        chk("simul_idx", grant_idx, 4'd9);
        chk("simul_nopre2", preempt, 1'b0);
        $display("simultaneous release scenario done");

        // Randomized traffic with varying density and rare resets.
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] r;
            logic        rr;
            case ($urandom_range(0, 3))
                0: r = 16'($urandom) & 16'($urandom) & 16'($urandom);
                1: r = 16'(1 << $urandom_range(0, 15));
                2: r = 16'($urandom);
                default: r = req;
            endcase
            rr = ($urandom_range(0, 199) == 0);
            step(rr, r);
        end
        $display("random traffic done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
